// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: shared types and helpers for fifo_sync_dist.
//   read_mode_e  - read-side behaviour, mapped from the READ_MODE string
//   os_state_e   - FWFT output-register state
//   clog2_safe   - ceil(log2(n)), never less than 1
package fifo_sync_pkg;

  typedef enum logic {
    RM_STD  = 1'b0,
    RM_FWFT = 1'b1
  } read_mode_e;

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_VALID = 1'b1
  } os_state_e;

  // Bounded loop so the function stays usable in constant expressions
  // and synthesis; a 1-bit result is the minimum so degenerate sizes
  // never produce zero-width vectors.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dist_ram_sdp.sv
// dist_ram_sdp: simple dual-port RAM, DEPTH x WIDTH.
//   clk   - write clock
//   we    - write enable (synchronous write)
//   waddr - write address
//   wdata - write word
//   raddr - read address (asynchronous read)
//   rdata - word at raddr, combinational
// Asynchronous read with no reset on the array keeps this in LUT RAM.
module dist_ram_sdp #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_dist.sv
// fifo_sync_dist: single-clock FIFO on distributed RAM with standard or
// first-word-fall-through read mode.
//   clk, rst           - clock, asynchronous active-high reset
//   wr_en, wr_data     - write request and word
//   wr_ack, overflow   - registered pulses: write accepted / write dropped
//   rd_en              - read request (std) or consume head word (fwft)
//   rd_data, rd_valid  - registered read word and its valid flag
//   underflow          - registered pulse: read while empty
//   full, empty, prog_full, prog_empty - status flags
//   count              - words held, including the FWFT output register
//   os_state           - FWFT output-register state (OS_EMPTY in std mode)
//
// Handshake: a write is accepted on any edge where wr_en=1 and full=0; a
// read is accepted on any edge where rd_en=1 and empty=0. Requests made
// while full/empty are dropped and reported by overflow/underflow on the
// following cycle. A read never frees room for a write on the same edge.
module fifo_sync_dist
  import fifo_sync_pkg::*;
#(
  parameter int    DATA_WIDTH        = 8,
  parameter int    FIFO_DEPTH        = 32,
  parameter string READ_MODE         = "std",
  parameter int    PROG_FULL_THRESH  = 24,
  parameter int    PROG_EMPTY_THRESH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               wr_ack,
  output logic                               overflow,
  input  logic                               rd_en,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic                               underflow,
  output logic                               full,
  output logic                               empty,
  output logic                               prog_full,
  output logic                               prog_empty,
  output logic [clog2_safe(FIFO_DEPTH):0]    count,
  output os_state_e                          os_state
);

  localparam int AW = clog2_safe(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam read_mode_e RM = (READ_MODE == "fwft") ? RM_FWFT : RM_STD;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

  // Elaboration-time parameter checks.
  if (FIFO_DEPTH < 16 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_dist: FIFO_DEPTH must be a power of two in 16..256");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_width
    $error("fifo_sync_dist: DATA_WIDTH must be in 1..256");
  end
  if (READ_MODE != "std" && READ_MODE != "fwft") begin : g_bad_mode
    $error("fifo_sync_dist: READ_MODE must be \"std\" or \"fwft\"");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > FIFO_DEPTH - 1) begin : g_bad_pf
    $error("fifo_sync_dist: PROG_FULL_THRESH out of range");
  end
  if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > FIFO_DEPTH - 2) begin : g_bad_pe
    $error("fifo_sync_dist: PROG_EMPTY_THRESH out of range");
  end

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;     // pop the RAM head into rd_data
  logic                  valid_nxt;
  logic [CW-1:0]         ram_occ;    // words still in RAM (excludes FWFT stage)

  dist_ram_sdp #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Flags come straight from the registered count / rd_valid.
  assign full       = (count == DEPTH_C);
  assign prog_full  = (count >= PF_C);
  assign prog_empty = (count <= PE_C);
  assign empty      = (RM == RM_FWFT) ? ~rd_valid : (count == '0);

  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = 1'b0;
    ram_rd    = 1'b0;
    valid_nxt = 1'b0;
    ram_occ   = count;
    if (RM == RM_FWFT) begin
      ram_occ   = count - CW'(rd_valid);
      rd_acc    = rd_en & rd_valid;
      // Refill the output register whenever it is empty or being consumed,
      // so a steady stream sees no bubble.
      ram_rd    = (ram_occ != '0) & (~rd_valid | rd_en);
      valid_nxt = ram_rd | (rd_valid & ~rd_en);
    end else begin
      rd_acc    = rd_en & ~empty;
      ram_rd    = rd_acc;
      valid_nxt = rd_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      os_state  <= OS_EMPTY;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      rd_valid  <= valid_nxt;

      // Depth is a power of two, so pointer wrap is plain overflow.
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (ram_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= ram_q;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (RM == RM_FWFT) begin
        case (os_state)
          OS_EMPTY: if (ram_rd) os_state <= OS_VALID;
          OS_VALID: if (rd_en && !ram_rd) os_state <= OS_EMPTY;
          default:  os_state <= OS_EMPTY;
        endcase
      end else begin
        os_state <= OS_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_dist.sv
module tb_fifo_sync_dist;
  import fifo_sync_pkg::*;

  typedef struct packed {
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_ack;
    logic       overflow;
    logic       underflow;
    logic       full;
    logic       empty;
    logic       prog_full;
    logic       prog_empty;
    logic [4:0] count;
  } out_t;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    out_t       exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- std instance ----------------
  logic s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [7:0] s_wr_data = '0, s_rd_data;
  logic s_wr_ack, s_overflow, s_rd_valid, s_underflow;
  logic s_full, s_empty, s_prog_full, s_prog_empty;
  logic [4:0] s_count;
  os_state_e s_state;
  out_t s_out;

  fifo_sync_dist #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .READ_MODE("std"),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .wr_ack(s_wr_ack), .overflow(s_overflow), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .underflow(s_underflow),
    .full(s_full), .empty(s_empty), .prog_full(s_prog_full),
    .prog_empty(s_prog_empty), .count(s_count), .os_state(s_state)
  );

  assign s_out = {s_rd_data, s_rd_valid, s_wr_ack, s_overflow, s_underflow,
                  s_full, s_empty, s_prog_full, s_prog_empty, s_count};

  // ---------------- fwft instance ----------------
  logic f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [7:0] f_wr_data = '0, f_rd_data;
  logic f_wr_ack, f_overflow, f_rd_valid, f_underflow;
  logic f_full, f_empty, f_prog_full, f_prog_empty;
  logic [4:0] f_count;
  os_state_e f_state;
  out_t f_out;

  fifo_sync_dist #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .READ_MODE("fwft"),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .wr_ack(f_wr_ack), .overflow(f_overflow), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .underflow(f_underflow),
    .full(f_full), .empty(f_empty), .prog_full(f_prog_full),
    .prog_empty(f_prog_empty), .count(f_count), .os_state(f_state)
  );

  assign f_out = {f_rd_data, f_rd_valid, f_wr_ack, f_overflow, f_underflow,
                  f_full, f_empty, f_prog_full, f_prog_empty, f_count};

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[$];

  // Expected outputs; flags follow depth 16, prog_full 12, prog_empty 3.
  function automatic out_t mk(input logic [7:0] d, input logic v,
                              input logic ack, input logic ovf,
                              input logic unf, input int c, input logic emp);
    out_t o;
    o.rd_data    = d;
    o.rd_valid   = v;
    o.wr_ack     = ack;
    o.overflow   = ovf;
    o.underflow  = unf;
    o.full       = (c == 16);
    o.empty      = emp;
    o.prog_full  = (c >= 12);
    o.prog_empty = (c <= 3);
    o.count      = 5'(c);
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got data=%h v=%b ack=%b ovf=%b unf=%b full=%b emp=%b pf=%b pe=%b cnt=%0d, expected data=%h v=%b ack=%b ovf=%b unf=%b full=%b emp=%b pf=%b pe=%b cnt=%0d",
               name, act.rd_data, act.rd_valid, act.wr_ack, act.overflow,
               act.underflow, act.full, act.empty, act.prog_full,
               act.prog_empty, act.count, exp.rd_data, exp.rd_valid,
               exp.wr_ack, exp.overflow, exp.underflow, exp.full, exp.empty,
               exp.prog_full, exp.prog_empty, exp.count);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic std_cycle(input logic we, input logic [7:0] wd, input logic re);
    @(negedge clk);
    s_wr_en = we; s_wr_data = wd; s_rd_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic fwft_cycle(input logic we, input logic [7:0] wd, input logic re);
    @(negedge clk);
    f_wr_en = we; f_wr_data = wd; f_rd_en = re;
    @(posedge clk);
    #1;
  endtask

  // Push one table entry.
  task automatic add_vec(input logic we, input logic [7:0] wd, input logic re,
                         input out_t e);
    vec_t v;
    v.wr_en = we; v.wr_data = wd; v.rd_en = re; v.exp = e;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    int wi, got, bubbles;
    bit seen;
    logic [7:0] e;

    // Std-mode table: fill, full-with-read, drain, underflow, count=1 r/w.
    for (int i = 0; i < 16; i++)
      add_vec(1'b1, 8'(i + 1), 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, i + 1, 1'b0));
    add_vec(1'b1, 8'hEE, 1'b1, mk(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 15, 1'b0));
    for (int k = 1; k <= 15; k++)
      add_vec(1'b0, 8'h00, 1'b1, mk(8'(k + 1), 1'b1, 1'b0, 1'b0, 1'b0, 15 - k, (k == 15)));
    add_vec(1'b0, 8'h00, 1'b1, mk(8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1));
    add_vec(1'b1, 8'h55, 1'b0, mk(8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0));
    add_vec(1'b1, 8'h66, 1'b1, mk(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0));
    add_vec(1'b0, 8'h00, 1'b1, mk(8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    add_vec(1'b0, 8'h00, 1'b0, mk(8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));

    // Reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_std", s_out, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    check_out("reset_fwft", f_out, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    check_val("reset_fwft_state", int'(f_state), int'(OS_EMPTY));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven std vectors.
    foreach (vecs[i]) begin
      std_cycle(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
      check_out($sformatf("std_vec%0d", i), s_out, vecs[i].exp);
    end
    std_cycle(1'b0, 8'h00, 1'b0);

    // FWFT single word: visible two edges after the write, no rd_en.
    fwft_cycle(1'b1, 8'hA5, 1'b0);
    check_out("fwft_wr", f_out, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1));
    fwft_cycle(1'b0, 8'h00, 1'b0);
    check_out("fwft_head", f_out, mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0));
    check_val("fwft_state_valid", int'(f_state), int'(OS_VALID));
    fwft_cycle(1'b0, 8'h00, 1'b1);
    check_out("fwft_pop", f_out, mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    fwft_cycle(1'b0, 8'h00, 1'b1);
    check_out("fwft_underflow", f_out, mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1));

    // FWFT streaming 0..39 with rd_en held high.
    wi = 0; got = 0; bubbles = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 120 && got < 40; cyc++) begin
      @(negedge clk);
      if (f_rd_valid) begin
        seen = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check_val($sformatf("fwft_stream%0d", got), int'(f_rd_data), int'(e));
        got++;
      end else if (seen) begin
        bubbles++;
      end
      f_wr_en = (wi < 40);
      f_wr_data = wi[7:0];
      f_rd_en = 1'b1;
      if (wi < 40) begin
        exp_q.push_back(wi[7:0]);
        wi++;
      end
      @(posedge clk);
    end
    #1;
    check_val("fwft_stream_words", got, 40);
    check_val("fwft_stream_bubbles", bubbles, 0);
    check_val("fwft_stream_count", int'(f_count), 0);
    check_val("fwft_stream_empty", int'(f_empty), 1);
    fwft_cycle(1'b0, 8'h00, 1'b0);

    // Mid-stream async reset at count 9.
    for (int i = 0; i < 9; i++) std_cycle(1'b1, 8'(8'h20 + i), 1'b0);
    check_out("pre_reset", s_out, mk(8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b0));
    @(negedge clk);
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check_out("async_reset_std", s_out, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    check_out("async_reset_fwft", f_out, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    std_cycle(1'b1, 8'h77, 1'b0);
    check_out("post_reset_wr", s_out, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0));
    std_cycle(1'b0, 8'h00, 1'b1);
    check_out("post_reset_rd", s_out, mk(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    std_cycle(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
